sram64_resp: RTL

Responder for the core's 64-bit byte-enabled SRAM port. It receives the per-byte write enables, lane-aligned write data and address produced by the load/store translator, and services each access over a valid/ready memory bus. It stalls the core until the access completes, then returns the full 64-bit line on `sram_douta`. The block sits between the pipeline's memory stage and the data memory/interconnect.

---
 rtl/sram64_resp.sv | 129 ++++++++++++
 1 files changed

// File: rtl/sram64_resp.sv
// sram64_resp: services one 64-bit byte-enabled SRAM access at a time over a
// valid/ready memory bus. It holds the core in a stall until the bus answers
// or the wait times out, then returns the registered read line.
module sram64_resp #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        sram_en,
  input  logic [7:0]  sram_wea,
  input  logic [63:0] sram_addr,
  input  logic [63:0] sram_dina,
  output logic [63:0] sram_douta,
  output logic        sram_stall,
  output logic        sram_err,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [63:0] mem_req_addr,
  output logic [7:0]  mem_req_wstrb,
  output logic [63:0] mem_req_wdata,
  input  logic        mem_resp_valid,
  input  logic [63:0] mem_resp_rdata,
  input  logic        mem_resp_err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  // The counter is 16 bits wide, so only the low 16 bits of TIMEOUT matter.
  localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT);
  localparam bit          TIMEOUT_EN  = (TIMEOUT != 0);

  logic [1:0]  state;
  logic [1:0]  state_nxt;
  logic [60:0] req_line;
  logic [7:0]  req_wstrb;
  logic [63:0] req_wdata;
  logic [15:0] wait_cnt;
  logic [15:0] wait_cnt_inc;
  logic        timeout_hit;
  logic        err_flag;
  logic [63:0] douta_q;
  logic        unused_addr_bits;

  // The byte offset never reaches the bus; the line address is 8-byte aligned.
  assign unused_addr_bits = ^sram_addr[2:0];

  // The match is taken against the count this cycle would produce, so the
  // access ends after exactly TIMEOUT unanswered WAIT cycles.
  assign wait_cnt_inc = wait_cnt + 16'd1;
  assign timeout_hit  = TIMEOUT_EN && (wait_cnt_inc == TIMEOUT_CNT);

  // Next-state selection; a response always takes priority over the timeout.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (sram_en) state_nxt = S_REQ;
      S_REQ:  if (mem_req_ready) state_nxt = S_WAIT;
      S_WAIT: if (mem_resp_valid || timeout_hit) state_nxt = S_DONE;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register; reset abandons any access in flight.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Capture the core request once, so the bus sees stable fields until accepted.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      req_line  <= '0;
      req_wstrb <= '0;
      req_wdata <= '0;
    end else if (state == S_IDLE && sram_en) begin
      req_line  <= sram_addr[63:3];
      req_wstrb <= sram_wea;
      req_wdata <= sram_dina;
    end
  end

  // Count unanswered WAIT cycles, restarting when the bus accepts the request.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wait_cnt <= '0;
    end else if (state == S_REQ && mem_req_ready) begin
      wait_cnt <= '0;
    end else if (state == S_WAIT && !mem_resp_valid) begin
      wait_cnt <= wait_cnt_inc;
    end
  end

  // Completion result: read data on success, zero on any failure, and writes
  // that succeed leave the last read line in place.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      douta_q  <= '0;
      err_flag <= 1'b0;
    end else if (state == S_WAIT) begin
      if (mem_resp_valid) begin
        err_flag <= mem_resp_err;
        if (mem_resp_err) begin
          douta_q <= '0;
        end else if (req_wstrb == 8'h00) begin
          douta_q <= mem_resp_rdata;
        end
      end else if (timeout_hit) begin
        err_flag <= 1'b1;
        douta_q  <= '0;
      end
    end
  end

  assign sram_douta    = douta_q;
  assign sram_stall    = (state == S_IDLE && sram_en) || state == S_REQ || state == S_WAIT;
  assign sram_err      = (state == S_DONE) && err_flag;
  assign mem_req_valid = (state == S_REQ);
  assign mem_req_addr  = {req_line, 3'b000};
  assign mem_req_wstrb = req_wstrb;
  assign mem_req_wdata = req_wdata;

endmodule
